// File: rtl/sample_uart_tx_if.sv
// Sample stream into the UART serialiser plus its line/status outputs.
interface sample_uart_tx_if #(
    parameter int unsigned DATA_IN_LEN = 10,
    parameter int unsigned FIFO_DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_IN_LEN-1:0] data_in;
    logic                   strobe_in;
    logic                   tx_o;
    logic                   busy_o;
    logic                   overflow_o;
    logic [LVL_W-1:0]       fifo_level_o;

    modport master (
        output data_in, strobe_in,
        input  tx_o, busy_o, overflow_o, fifo_level_o
    );

    modport slave (
        input  data_in, strobe_in,
        output tx_o, busy_o, overflow_o, fifo_level_o
    );
endinterface

// File: rtl/sample_uart_tx.sv
// Buffers filter samples in a FIFO and sends each as two 8N1 bytes (sync bit in byte A).
// SAMPLE_UART_PARITY_EN adds an even-parity bit after the data bits of every byte.
module sample_uart_tx #(
    parameter int unsigned DATA_IN_LEN  = 10,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    sample_uart_tx_if.slave  io_bus
);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned EXT_W  = 14;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SAMPLE_UART_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [BAUD_W-1:0]      r_baud, w_baud_nxt;
    logic [2:0]             r_bit_idx, w_bit_idx_nxt;
    logic                   r_byte_b, w_byte_b_nxt;
    logic [DATA_IN_LEN-1:0] r_sample;
    logic                   r_tx, w_tx_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_overflow;

    logic [DATA_IN_LEN-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]       r_level, w_level_nxt;
    logic                   w_pop, w_push, w_full, w_drop, w_bit_end;
    logic [EXT_W-1:0]       w_ext;
    logic [7:0]             w_byte_nxt;

    // A full FIFO still accepts a strobe when the FSM pops in the same cycle.
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push    = io_bus.strobe_in & (~w_full | w_pop);
    assign w_drop    = io_bus.strobe_in & w_full & ~w_pop;
    assign w_bit_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + LVL_W'(1);
        else if (!w_push && w_pop)
            w_level_nxt = r_level - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= io_bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_nxt;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // FSM state register, including the baud/bit/byte sub-state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_byte_b  <= 1'b0;
            r_sample  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_byte_b  <= w_byte_b_nxt;
            if (w_pop)
                r_sample <= r_mem[r_rd_ptr];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud + BAUD_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_byte_b_nxt  = r_byte_b;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (r_level != '0) begin
                    w_state_nxt  = S_START;
                    w_byte_b_nxt = 1'b0;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef SAMPLE_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef SAMPLE_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (!r_byte_b) begin
                        w_state_nxt  = S_START;
                        w_byte_b_nxt = 1'b1;
                    end else if (r_level != '0) begin
                        w_state_nxt  = S_START;
                        w_byte_b_nxt = 1'b0;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Line level is computed for the state being entered, so tx_o registers cleanly.
    assign w_ext      = EXT_W'(r_sample);
    assign w_byte_nxt = w_byte_b_nxt ? {1'b0, w_ext[6:0]} : {1'b1, w_ext[13:7]};

    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != S_IDLE) | (w_level_nxt != '0);
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_byte_nxt[w_bit_idx_nxt];
`ifdef SAMPLE_UART_PARITY_EN
            S_PARITY: w_tx_nxt = ^w_byte_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign io_bus.tx_o         = r_tx;
    assign io_bus.busy_o       = r_busy;
    assign io_bus.overflow_o   = r_overflow;
    assign io_bus.fifo_level_o = r_level;
endmodule

// File: tb/tb_sample_uart_tx.sv
// Bench for sample_uart_tx: timeline reference model checked every cycle, plus line decoding.
module tb_sample_uart_tx;
    localparam int DW    = 10;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef SAMPLE_UART_PARITY_EN
    localparam int BPB = 11;
`else
    localparam int BPB = 10;
`endif
    localparam int FRAME = 2 * BPB * CPB;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    byte_a;
        logic [7:0]    byte_b;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_uart_tx_if #(.DATA_IN_LEN(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

    sample_uart_tx #(
        .DATA_IN_LEN (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: FIFO as a queue, each popped sample owns FRAME cycles of line time.
    logic [DW-1:0] m_q[$];
    int            m_start = 0;
    int            m_end   = 0;
    logic [21:0]   m_bits  = '1;
    logic          m_ovf   = 1'b0;

    logic tx_hist[$];
    logic busy_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [21:0] build_frame(input logic [DW-1:0] s);
        int          ev;
        logic [7:0]  b [2];
        logic [21:0] f;
        int          p;
        ev   = int'(s);
        b[0] = 8'(128 + ev / 128);
        b[1] = 8'(ev % 128);
        f    = '1;
        p    = 0;
        for (int k = 0; k < 2; k++) begin
            f[p] = 1'b0; p++;
            for (int i = 0; i < 8; i++) begin
                f[p] = b[k][i]; p++;
            end
`ifdef SAMPLE_UART_PARITY_EN
            f[p] = ^b[k]; p++;
`endif
            f[p] = 1'b1; p++;
        end
        return f;
    endfunction

    function automatic void model_edge(input logic s, input logic [DW-1:0] d, input logic r);
        logic [DW-1:0] head;
        logic          pop;
        logic          push;
        head = '0;
        if (r) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_end = cyc;
            return;
        end
        pop  = (m_q.size() != 0) && (cyc >= m_end);
        push = s && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            head    = m_q.pop_front();
            m_start = cyc;
            m_end   = cyc + FRAME;
            m_bits  = build_frame(head);
        end
        if (push)
            m_q.push_back(d);
        else if (s)
            m_ovf = 1'b1;
    endfunction

    function automatic logic m_tx();
        if (cyc < m_end)
            return m_bits[(cyc - m_start) / CPB];
        return 1'b1;
    endfunction

    task automatic step(input logic s, input logic [DW-1:0] d, input logic r);
        bus_if.strobe_in = s;
        bus_if.data_in   = d;
        reset            = r;
        @(posedge clk);
        model_edge(s, d, r);
        #1;
        chk("model_tx", 32'(bus_if.tx_o), 32'(m_tx()));
        chk("model_busy", 32'(bus_if.busy_o), 32'((cyc < m_end) || (m_q.size() != 0)));
        chk("model_level", 32'(bus_if.fifo_level_o), 32'(m_q.size()));
        chk("model_ovf", 32'(bus_if.overflow_o), 32'(m_ovf));
        tx_hist.push_back(bus_if.tx_o);
        busy_hist.push_back(bus_if.busy_o);
        cyc++;
    endtask

    function automatic int first_idx(input int sel, input int from, input logic val);
        int n;
        n = (sel == 0) ? tx_hist.size() : busy_hist.size();
        for (int i = from; i < n; i++) begin
            if (((sel == 0) ? tx_hist[i] : busy_hist[i]) == val)
                return i;
        end
        return -1;
    endfunction

    // Samples the recorded line mid-bit for one byte starting at index p.
    task automatic decode(input int p, output logic [7:0] b, output logic frm_ok, output logic par);
        b      = '0;
        frm_ok = (tx_hist[p + CPB/2] == 1'b0) && (tx_hist[p + (BPB-1)*CPB + CPB/2] == 1'b1);
        for (int i = 0; i < 8; i++)
            b[i] = tx_hist[p + (i+1)*CPB + CPB/2];
        par = tx_hist[p + 9*CPB + CPB/2];
    endtask

    initial begin
        vec_t       vecs [6];
        int         s;
        int         r;
        int         z;
        int         rate;
        int         rates [4];
        logic [7:0] ba, bb;
        logic       fa, fbk, pa, pb;

        vecs[0] = '{10'h2A5, 8'h85, 8'h25};
        vecs[1] = '{10'h000, 8'h80, 8'h00};
        vecs[2] = '{10'h3FF, 8'h87, 8'h7F};
        vecs[3] = '{10'h155, 8'h82, 8'h55};
        vecs[4] = '{10'h080, 8'h81, 8'h00};
        vecs[5] = '{10'h07F, 8'h80, 8'h7F};
        rates[0] = 1; rates[1] = 3; rates[2] = 10; rates[3] = 60;

        bus_if.strobe_in = 1'b0;
        bus_if.data_in   = '0;
        reset            = 1'b1;

        repeat (3) step(1'b0, '0, 1'b1);
        chk("reset_tx", 32'(bus_if.tx_o), 32'd1);
        chk("reset_busy", 32'(bus_if.busy_o), 32'd0);
        chk("reset_ovf", 32'(bus_if.overflow_o), 32'd0);
        chk("reset_level", 32'(bus_if.fifo_level_o), 32'd0);

        // Single samples: decode both bytes, start latency and busy fall.
        for (int v = 0; v < 6; v++) begin
            tx_hist.delete();
            busy_hist.delete();
            step(1'b1, vecs[v].data, 1'b0);
            repeat (FRAME + 4) step(1'b0, '0, 1'b0);
            s = first_idx(0, 0, 1'b0);
            chk("fall_edge", 32'(s), 32'd1);
            if (s >= 0) begin
                decode(s, ba, fa, pa);
                decode(s + BPB*CPB, bb, fbk, pb);
                chk("byte_a", 32'(ba), 32'(vecs[v].byte_a));
                chk("byte_b", 32'(bb), 32'(vecs[v].byte_b));
                chk("framing", 32'({fa, fbk}), 32'd3);
`ifdef SAMPLE_UART_PARITY_EN
                chk("parity_a", 32'(pa), 32'(^vecs[v].byte_a));
                chk("parity_b", 32'(pb), 32'(^vecs[v].byte_b));
`endif
                chk("busy_fall", 32'(first_idx(1, s, 1'b0)), 32'(s + FRAME));
            end
        end

        // Six back-to-back strobes: the sixth is dropped, five frames run without gaps.
        tx_hist.delete();
        busy_hist.delete();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == 5)
                chk("ovf_before_6th", 32'(bus_if.overflow_o), 32'd0);
        end
        chk("ovf_6th", 32'(bus_if.overflow_o), 32'd1);
        chk("ovf_level", 32'(bus_if.fifo_level_o), 32'd4);
        repeat (5*FRAME + 6) step(1'b0, '0, 1'b0);
        s = first_idx(0, 0, 1'b0);
        chk("burst_fall_edge", 32'(s), 32'd1);
        if (s >= 0) begin
            for (int n = 0; n < 5; n++) begin
                decode(s + n*FRAME, ba, fa, pa);
                decode(s + n*FRAME + BPB*CPB, bb, fbk, pb);
                chk("burst_byte_a", 32'(ba), 32'(8'h80 | 8'((n+1) / 128)));
                chk("burst_byte_b", 32'(bb), 32'(8'((n+1) % 128)));
                chk("burst_framing", 32'({fa, fbk}), 32'd3);
            end
            chk("burst_busy_fall", 32'(first_idx(1, s, 1'b0)), 32'(s + 5*FRAME));
        end

        // Reset in the middle of byte A data bits with two samples queued.
        tx_hist.delete();
        busy_hist.delete();
        step(1'b1, DW'(10'h111), 1'b0);
        step(1'b1, DW'(10'h222), 1'b0);
        step(1'b1, DW'(10'h333), 1'b0);
        repeat (2*CPB + 2) step(1'b0, '0, 1'b0);
        chk("pre_rst_level", 32'(bus_if.fifo_level_o), 32'd2);
        step(1'b0, '0, 1'b1);
        chk("rst_tx", 32'(bus_if.tx_o), 32'd1);
        chk("rst_level", 32'(bus_if.fifo_level_o), 32'd0);
        chk("rst_busy", 32'(bus_if.busy_o), 32'd0);
        chk("rst_ovf", 32'(bus_if.overflow_o), 32'd0);
        r = tx_hist.size();
        repeat (3*FRAME) step(1'b0, '0, 1'b0);
        z = 0;
        for (int i = r; i < tx_hist.size(); i++)
            if (tx_hist[i] == 1'b0) z++;
        chk("post_rst_quiet", 32'(z), 32'd0);

        // Full FIFO, strobe on the edge that ends byte B's stop bit.
        for (int i = 0; i < 5; i++)
            step(1'b1, DW'(64 + i), 1'b0);
        chk("ff_level_full", 32'(bus_if.fifo_level_o), 32'd4);
        repeat (FRAME - 4) step(1'b0, '0, 1'b0);
        chk("ff_level_pre", 32'(bus_if.fifo_level_o), 32'd4);
        step(1'b1, DW'(10'h3C3), 1'b0);
        chk("ff_level_post", 32'(bus_if.fifo_level_o), 32'd4);
        chk("ff_ovf", 32'(bus_if.overflow_o), 32'd0);
        repeat (5*FRAME + 4) step(1'b0, '0, 1'b0);

        // Randomized traffic at varying strobe rates with rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            rate = rates[$urandom_range(0, 3)];
            repeat (500)
                step(($urandom_range(0, 99) < rate), DW'($urandom_range(0, 1023)),
                     ($urandom_range(0, 999) == 0));
        end
        repeat (6*FRAME) step(1'b0, '0, 1'b0);
        chk("final_idle_busy", 32'(bus_if.busy_o), 32'd0);
        chk("final_idle_tx", 32'(bus_if.tx_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
